// File: rtl/irq_pkg.sv
// irq_pkg: shared types and constants for the interrupt controller.
// FSM state encoding, source indices and cause-code width.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int SRC_TIMER = 0;
  localparam int SRC_EXT   = 1;
  localparam int CAUSE_W   = 4;

endpackage

// File: rtl/irq_sync.sv
// irq_sync: STAGES-deep synchroniser chain, async active-low reset.
// Ports: clk, rstn, d (async level in), q (synchronised level out).
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-latched two-source interrupt controller with
// fixed priority, registered request/cause and timed source ack.
// Ports: clk, rstn, timer_int, external_int, irq_en, irq_mask,
// cpu_irq_ack -> irq_req, irq_cause, timer_int_ack, ext_int_ack,
// irq_pending.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int EXT_HIGH_PRIO = 1,
  parameter int ACK_LEN       = 1,
  parameter int TIMER_CAUSE   = 7,
  parameter int EXT_CAUSE     = 11
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               timer_int,
  input  logic               external_int,
  input  logic               irq_en,
  input  logic [1:0]         irq_mask,
  input  logic               cpu_irq_ack,
  output logic               irq_req,
  output logic [CAUSE_W-1:0] irq_cause,
  output logic               timer_int_ack,
  output logic               ext_int_ack,
  output logic [1:0]         irq_pending
);

  localparam logic [3:0] ACK_CNT =
    4'(ACK_LEN - 1);
  localparam logic [CAUSE_W-1:0] T_CAUSE =
    CAUSE_W'(TIMER_CAUSE);
  localparam logic [CAUSE_W-1:0] E_CAUSE =
    CAUSE_W'(EXT_CAUSE);

  state_t     state;
  logic       ext_sync;
  logic [1:0] lvl;
  logic [1:0] prev;
  logic [1:0] rise;
  logic [1:0] pend;
  logic [1:0] clr;
  logic [1:0] elig;
  logic       win;
  logic       win_nxt;
  logic [3:0] cnt;

  irq_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (external_int),
    .q   (ext_sync)
  );

  assign lvl  = {ext_sync, timer_int};
  assign rise = lvl & ~prev;

  // win: 0 = timer, 1 = external.
  always_comb begin
    elig = pend & irq_mask & {2{irq_en}};
    if (EXT_HIGH_PRIO != 0) begin
      win_nxt = elig[SRC_EXT];
    end else begin
      win_nxt = ~elig[SRC_TIMER];
    end
  end

  // Pending bit of the winner drops as its ack starts.
  always_comb begin
    clr = 2'b00;
    if (state == REQ && cpu_irq_ack) begin
      clr[win] = 1'b1;
    end
  end

  // A new edge in the clear cycle must not be lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev <= 2'b00;
      pend <= 2'b00;
    end else begin
      prev <= lvl;
      pend <= (pend & ~clr) | rise;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      irq_req       <= 1'b0;
      irq_cause     <= '0;
      win           <= 1'b0;
      cnt           <= 4'd0;
      timer_int_ack <= 1'b0;
      ext_int_ack   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|elig) begin
            win       <= win_nxt;
            irq_cause <= win_nxt ? E_CAUSE
                                 : T_CAUSE;
            irq_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (cpu_irq_ack) begin
            irq_req       <= 1'b0;
            cnt           <= ACK_CNT;
            timer_int_ack <= ~win;
            ext_int_ack   <= win;
            state         <= ACK;
          end else if (!irq_en ||
                       !irq_mask[win]) begin
            irq_req <= 1'b0;
            state   <= IDLE;
          end
        end
        ACK: begin
          if (cnt == 4'd0) begin
            timer_int_ack <= 1'b0;
            ext_int_ack   <= 1'b0;
            state         <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign irq_pending = pend;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: scenario and random checks of two irq_ctrl
// configurations against a behavioural reference model.
module tb_irq_ctrl;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       timer_int = 1'b0;
  logic       external_int = 1'b0;
  logic       irq_en = 1'b0;
  logic [1:0] irq_mask = 2'b00;
  logic       cpu_irq_ack = 1'b0;

  logic       req0, req1;
  logic [3:0] cause0, cause1;
  logic       tack0, tack1, eack0, eack1;
  logic [1:0] pend0, pend1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  irq_ctrl #(
    .SYNC_STAGES(SYNC), .EXT_HIGH_PRIO(1), .ACK_LEN(3),
    .TIMER_CAUSE(7), .EXT_CAUSE(11)
  ) u0 (
    .clk(clk), .rstn(rstn), .timer_int(timer_int),
    .external_int(external_int), .irq_en(irq_en),
    .irq_mask(irq_mask), .cpu_irq_ack(cpu_irq_ack),
    .irq_req(req0), .irq_cause(cause0),
    .timer_int_ack(tack0), .ext_int_ack(eack0),
    .irq_pending(pend0)
  );

  irq_ctrl #(
    .SYNC_STAGES(SYNC), .EXT_HIGH_PRIO(0), .ACK_LEN(1),
    .TIMER_CAUSE(7), .EXT_CAUSE(11)
  ) u1 (
    .clk(clk), .rstn(rstn), .timer_int(timer_int),
    .external_int(external_int), .irq_en(irq_en),
    .irq_mask(irq_mask), .cpu_irq_ack(cpu_irq_ack),
    .irq_req(req1), .irq_cause(cause1),
    .timer_int_ack(tack1), .ext_int_ack(eack1),
    .irq_pending(pend1)
  );

  logic [8:0] obs [2];
  assign obs[0] = {req0, cause0, tack0, eack0, pend0};
  assign obs[1] = {req1, cause1, tack1, eack1, pend1};

  // Reference model: per-DUT request flag, winner, remaining ack
  // cycles; input histories give edge timing directly.
  logic       m_req   [2];
  logic [3:0] m_cause [2];
  int         m_win   [2];
  int         m_rem   [2];
  logic [1:0] m_pend  [2];
  logic       he [6];
  logic       ht [2];

  function automatic logic [8:0] expv(input int d);
    logic t, e;
    t = (m_rem[d] > 0) && (m_win[d] == 0);
    e = (m_rem[d] > 0) && (m_win[d] == 1);
    return {m_req[d], m_cause[d], t, e, m_pend[d]};
  endfunction

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      m_req[d] = 1'b0; m_cause[d] = 4'd0;
      m_win[d] = 0; m_rem[d] = 0; m_pend[d] = 2'b00;
    end
    for (int k = 0; k < 6; k++) he[k] = 1'b0;
    ht[0] = 1'b0; ht[1] = 1'b0;
  endtask

  task automatic step();
    logic [1:0] el, rise, clr;
    if (!rstn) begin
      mreset();
    end else begin
      for (int k = 5; k > 0; k--) he[k] = he[k-1];
      he[0] = external_int;
      ht[1] = ht[0];
      ht[0] = timer_int;
      rise = {he[SYNC] & ~he[SYNC+1], ht[0] & ~ht[1]};
      for (int d = 0; d < 2; d++) begin
        el = m_pend[d] & irq_mask & {2{irq_en}};
        clr = 2'b00;
        if (m_req[d]) begin
          if (cpu_irq_ack) begin
            m_req[d] = 1'b0;
            m_rem[d] = (d == 0) ? 3 : 1;
            clr[m_win[d]] = 1'b1;
          end else if (!irq_en || !irq_mask[m_win[d]]) begin
            m_req[d] = 1'b0;
          end
        end else if (m_rem[d] > 0) begin
          m_rem[d]--;
        end else if (el != 2'b00) begin
          if (d == 0) m_win[d] = el[1] ? 1 : 0;
          else        m_win[d] = el[0] ? 0 : 1;
          m_req[d] = 1'b1;
          m_cause[d] = (m_win[d] == 1) ? 4'd11 : 4'd7;
        end
        m_pend[d] = (m_pend[d] & ~clr) | rise;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mreset();
    #1 rstn = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs[d] !== 9'd0) begin
        bad++;
        $display("FAIL reset dut%0d got=%b exp=%b", d, obs[d], 9'd0);
      end
    end
    repeat (2) begin
      step();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs[d] !== expv(d)) begin
          bad++;
          $display("FAIL rst_hold dut%0d got=%b exp=%b", d, obs[d], expv(d));
        end
      end
    end
    rstn = 1'b1;
    irq_en = 1'b1;
    irq_mask = 2'b11;
    repeat (3) begin
      step();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs[d] !== expv(d)) begin
          bad++;
          $display("FAIL rst_rel dut%0d got=%b exp=%b", d, obs[d], expv(d));
        end
      end
    end
  endtask

  task automatic test_timer_only();
    timer_int = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs[d] !== expv(d)) begin
          bad++;
          $display("FAIL timer dut%0d got=%b exp=%b", d, obs[d], expv(d));
        end
      end
      if (c == 1) begin
        total++;
        if ({req0, req1} !== 2'b00) begin
          bad++;
          $display("FAIL timer_early got=%b exp=00", {req0, req1});
        end
      end
      if (c == 2) begin
        total++;
        if ({req0, cause0, req1, cause1} !== 10'b10111_10111) begin
          bad++;
          $display("FAIL timer_lat got=%b exp=1011110111",
                   {req0, cause0, req1, cause1});
        end
      end
    end
    cpu_irq_ack = 1'b1;
    step();
    cpu_irq_ack = 1'b0;
    total++;
    if ({req0, tack0, pend0[0], req1, tack1, pend1[0]} !== 6'b010_010) begin
      bad++;
      $display("FAIL timer_ack got=%b exp=010010",
               {req0, tack0, pend0[0], req1, tack1, pend1[0]});
    end
    timer_int = 1'b0;
    repeat (4) begin
      step();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs[d] !== expv(d)) begin
          bad++;
          $display("FAIL timer_end dut%0d got=%b exp=%b", d, obs[d], expv(d));
        end
      end
    end
  endtask

  task automatic test_both_prio();
    external_int = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 2) timer_int = 1'b1;
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs[d] !== expv(d)) begin
          bad++;
          $display("FAIL both dut%0d got=%b exp=%b", d, obs[d], expv(d));
        end
      end
    end
    total++;
    if ({req0, cause0, req1, cause1} !== 10'b11011_10111) begin
      bad++;
      $display("FAIL prio_first got=%b exp=1101110111",
               {req0, cause0, req1, cause1});
    end
    cpu_irq_ack = 1'b1;
    step();
    cpu_irq_ack = 1'b0;
    external_int = 1'b0;
    timer_int = 1'b0;
    repeat (4) begin
      step();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs[d] !== expv(d)) begin
          bad++;
          $display("FAIL both2 dut%0d got=%b exp=%b", d, obs[d], expv(d));
        end
      end
    end
    total++;
    if ({req0, cause0, req1, cause1} !== 10'b10111_11011) begin
      bad++;
      $display("FAIL prio_second got=%b exp=1011111011",
               {req0, cause0, req1, cause1});
    end
    cpu_irq_ack = 1'b1;
    step();
    cpu_irq_ack = 1'b0;
    repeat (5) begin
      step();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs[d] !== expv(d)) begin
          bad++;
          $display("FAIL both3 dut%0d got=%b exp=%b", d, obs[d], expv(d));
        end
      end
    end
  endtask

  task automatic test_en_drop();
    timer_int = 1'b1;
    repeat (2) step();
    irq_en = 1'b0;
    step();
    total++;
    if ({req0, tack0, pend0, req1, tack1, pend1} !== 8'b0001_0001) begin
      bad++;
      $display("FAIL en_drop got=%b exp=00010001",
               {req0, tack0, pend0, req1, tack1, pend1});
    end
    repeat (2) begin
      step();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs[d] !== expv(d)) begin
          bad++;
          $display("FAIL en_off dut%0d got=%b exp=%b", d, obs[d], expv(d));
        end
      end
    end
    irq_en = 1'b1;
    step();
    total++;
    if ({req0, cause0, req1, cause1} !== 10'b10111_10111) begin
      bad++;
      $display("FAIL en_rearm got=%b exp=1011110111",
               {req0, cause0, req1, cause1});
    end
    cpu_irq_ack = 1'b1;
    step();
    cpu_irq_ack = 1'b0;
    timer_int = 1'b0;
    repeat (4) begin
      step();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs[d] !== expv(d)) begin
          bad++;
          $display("FAIL en_end dut%0d got=%b exp=%b", d, obs[d], expv(d));
        end
      end
    end
  endtask

  task automatic test_mask();
    irq_mask = 2'b01;
    external_int = 1'b1;
    repeat (6) step();
    total++;
    if ({req0, pend0, req1, pend1} !== 6'b010_010) begin
      bad++;
      $display("FAIL mask_block got=%b exp=010010",
               {req0, pend0, req1, pend1});
    end
    irq_mask = 2'b11;
    step();
    total++;
    if ({req0, cause0, req1, cause1} !== 10'b11011_11011) begin
      bad++;
      $display("FAIL mask_open got=%b exp=1101111011",
               {req0, cause0, req1, cause1});
    end
    cpu_irq_ack = 1'b1;
    step();
    cpu_irq_ack = 1'b0;
    external_int = 1'b0;
    repeat (4) begin
      step();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs[d] !== expv(d)) begin
          bad++;
          $display("FAIL mask_end dut%0d got=%b exp=%b", d, obs[d], expv(d));
        end
      end
    end
  endtask

  task automatic test_ack_len();
    int n0, n1, f0, f1;
    external_int = 1'b1;
    repeat (4) step();
    cpu_irq_ack = 1'b1;
    step();
    cpu_irq_ack = 1'b0;
    external_int = 1'b0;
    timer_int = 1'b1;
    n0 = int'(eack0);
    n1 = int'(eack1);
    f0 = -1;
    f1 = -1;
    for (int i = 1; i <= 7; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs[d] !== expv(d)) begin
          bad++;
          $display("FAIL acklen dut%0d got=%b exp=%b", d, obs[d], expv(d));
        end
      end
      n0 += int'(eack0);
      n1 += int'(eack1);
      if (req0 && f0 < 0) f0 = i;
      if (req1 && f1 < 0) f1 = i;
    end
    total++;
    if (n0 !== 3 || n1 !== 1) begin
      bad++;
      $display("FAIL ack_cycles got=%0d,%0d exp=3,1", n0, n1);
    end
    total++;
    if (f0 !== 4 || f1 !== 2) begin
      bad++;
      $display("FAIL after_ack got=%0d,%0d exp=4,2", f0, f1);
    end
    cpu_irq_ack = 1'b1;
    step();
    cpu_irq_ack = 1'b0;
    timer_int = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset_mid_ack();
    timer_int = 1'b1;
    repeat (2) step();
    external_int = 1'b1;
    cpu_irq_ack = 1'b1;
    step();
    cpu_irq_ack = 1'b0;
    step();
    total++;
    if (tack0 !== 1'b1) begin
      bad++;
      $display("FAIL pre_rst got=%b exp=1", tack0);
    end
    rstn = 1'b0;
    mreset();
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs[d] !== 9'd0) begin
        bad++;
        $display("FAIL rst_async dut%0d got=%b exp=%b", d, obs[d], 9'd0);
      end
    end
    timer_int = 1'b0;
    external_int = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
    repeat (8) begin
      step();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs[d] !== expv(d)) begin
          bad++;
          $display("FAIL rst_after dut%0d got=%b exp=%b", d, obs[d], expv(d));
        end
      end
      total++;
      if ({req0, req1} !== 2'b00) begin
        bad++;
        $display("FAIL spurious got=%b exp=00", {req0, req1});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) timer_int = ~timer_int;
      if ($urandom_range(0, 9) == 0) external_int = ~external_int;
      irq_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) irq_mask = 2'($urandom);
      cpu_irq_ack = ($urandom_range(0, 3) == 0);
      step();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs[d] !== expv(d)) begin
          bad++;
          $display("FAIL random dut%0d cyc=%0d got=%b exp=%b",
                   d, i, obs[d], expv(d));
        end
      end
    end
    cpu_irq_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_timer_only();
    test_both_prio();
    test_en_drop();
    test_mask();
    test_ack_len();
    test_reset_mid_ack();
    irq_en = 1'b1;
    irq_mask = 2'b11;
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
